// File: rtl/pe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pe_pkg                                                       |
// | Description : Shared types and constants for the matrix PE datapath.       |
// |               Holds the partial-sum accumulator state encoding and the     |
// |               default data/counter widths.                                 |
// | Revision    : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package pe_pkg;

  localparam int PE_DATA_W = 32;
  localparam int PE_CNT_W  = 8;

  typedef enum logic [1:0] {
    PSUM_IDLE = 2'd0,
    PSUM_ACC  = 2'd1,
    PSUM_DONE = 2'd2
  } psum_state_e;

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_psum_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pe_psum_acc                                                  |
// | Description : Sums vec_num consecutive partial dot products from the       |
// |               adder tree into one result, with sticky signed-overflow      |
// |               flag, presented on a valid/ready handshake.                  |
// | Ports       : clk, rst        - clock, synchronous active-high reset       |
// |               vec_num         - chunks per result (0 treated as 1)         |
// |               psum_in/valid/ready - chunk input handshake                  |
// |               res_data/ovf/valid/ready - result output handshake           |
// |               busy            - accumulation in progress or result pending |
// | Revision    : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module pe_psum_acc
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int CNT_W  = PE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  vec_num,
  input  logic [DATA_W-1:0] psum_in,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  psum_state_e       state_q, state_d;
  logic [DATA_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [CNT_W-1:0]  len_q,   len_d;
  logic              ovf_q,   ovf_d;

  logic              w_accept;
  logic [DATA_W-1:0] w_sum;
  logic              w_sum_ovf;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_len_first;

  // Ready is a pure decode of the registered state, so there is no
  // combinational path from psum_valid.
  assign psum_ready = (state_q != PSUM_DONE);
  assign busy       = (state_q != PSUM_IDLE);
  assign res_valid  = (state_q == PSUM_DONE);
  assign res_data   = acc_q;
  assign res_ovf    = ovf_q;

  assign w_accept    = psum_valid && psum_ready;
  assign w_sum       = acc_q + psum_in;
  // Signed overflow: operands agree in sign, result sign differs.
  assign w_sum_ovf   = (acc_q[DATA_W-1] == psum_in[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != acc_q[DATA_W-1]);
  assign w_cnt_inc   = cnt_q + CNT_W'(1);
  assign w_len_first = (vec_num == '0) ? CNT_W'(1) : vec_num;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      PSUM_IDLE: begin
        if (w_accept) begin
          acc_d   = psum_in;
          cnt_d   = CNT_W'(1);
          len_d   = w_len_first;
          ovf_d   = 1'b0;
          state_d = (w_len_first == CNT_W'(1)) ? PSUM_DONE : PSUM_ACC;
        end
      end
      PSUM_ACC: begin
        if (w_accept) begin
          acc_d = w_sum;
          cnt_d = w_cnt_inc;
          ovf_d = ovf_q | w_sum_ovf;
          if (w_cnt_inc == len_q) begin
            state_d = PSUM_DONE;
          end
        end
      end
      PSUM_DONE: begin
        if (res_ready) begin
          state_d = PSUM_IDLE;
        end
      end
      default: begin
        state_d = PSUM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PSUM_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule : pe_psum_acc
`default_nettype wire
